// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, ALU operation
// classes, opcode/funct fields and ALUControl codes.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'd0,
        ALUOP_SUB   = 2'd1,
        ALUOP_FUNCT = 2'd2
    } aluop_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mips_alu_decoder.sv
// Maps the FSM's ALU operation class plus the instruction funct field to ALUControl.
module mips_alu_decoder
    import mips_ctrl_pkg::*;
(
    input  aluop_t      alu_op,
    input  logic [5:0]  funct,
    output logic [2:0]  alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_control = ALU_ADD;
                    FN_SUB:  alu_control = ALU_SUB;
                    FN_AND:  alu_control = ALU_AND;
                    FN_OR:   alu_control = ALU_OR;
                    FN_SLT:  alu_control = ALU_SLT;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore control FSM for the multicycle MIPS core; memory states wait on mem_ready and
// every output is forced low while reset_n is held.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [5:0]  Op,
    input  logic [5:0]  Funct,
    input  logic        Zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        IorD,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegDst,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ALUControl,
    output logic [1:0]  PCSrc,
    output logic        PCEn,
    output logic        illegal_op,
    output logic [3:0]  state
);

    state_t     state_q;
    aluop_t     alu_op;
    logic       alu_en;
    logic       pc_write;
    logic       branch;
    logic [2:0] alu_dec;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
        end else begin
            case (state_q)
                S_FETCH:   if (mem_ready) state_q <= S_DECODE;
                S_DECODE: begin
                    case (Op)
                        OP_LW, OP_SW: state_q <= S_MEMADR;
                        OP_RTYPE:     state_q <= S_EXECUTE;
                        OP_BEQ:       state_q <= S_BRANCH;
                        OP_ADDI:      state_q <= S_ADDIEX;
                        OP_J:         state_q <= S_JUMP;
                        default:      state_q <= S_FETCH;
                    endcase
                end
                S_MEMADR:  state_q <= (Op == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:   if (mem_ready) state_q <= S_MEMWB;
                S_MEMWR:   if (mem_ready) state_q <= S_FETCH;
                S_EXECUTE: state_q <= S_ALUWB;
                S_ADDIEX:  state_q <= S_ADDIWB;
                default:   state_q <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        mem_req    = 1'b0;
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        PCSrc      = 2'b00;
        illegal_op = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        alu_en     = 1'b0;
        alu_op     = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                // IR load and PC+4 commit only on the handshake cycle
                mem_req  = 1'b1;
                ALUSrcB  = 2'b01;
                alu_en   = 1'b1;
                IRWrite  = mem_ready;
                pc_write = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                alu_en  = 1'b1;
                case (Op)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal_op = 1'b0;
                    default:                                      illegal_op = 1'b1;
                endcase
            end
            S_MEMADR, S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                alu_en  = 1'b1;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWR: begin
                mem_req  = 1'b1;
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                alu_en  = 1'b1;
                alu_op  = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_ADDIWB: RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA = 1'b1;
                alu_en  = 1'b1;
                alu_op  = ALUOP_SUB;
                PCSrc   = 2'b01;
                branch  = 1'b1;
            end
            S_JUMP: begin
                PCSrc    = 2'b10;
                pc_write = 1'b1;
            end
            default: begin
                mem_req = 1'b0;
            end
        endcase
        // Reset overrides the decode so an in-flight access drops asynchronously
        if (!reset_n) begin
            mem_req    = 1'b0;
            IorD       = 1'b0;
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            RegDst     = 1'b0;
            MemtoReg   = 1'b0;
            RegWrite   = 1'b0;
            ALUSrcA    = 1'b0;
            ALUSrcB    = 2'b00;
            PCSrc      = 2'b00;
            illegal_op = 1'b0;
            pc_write   = 1'b0;
            branch     = 1'b0;
            alu_en     = 1'b0;
        end
    end

    mips_alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct       (Funct),
        .alu_control (alu_dec)
    );

    assign ALUControl = alu_en ? alu_dec : 3'b000;
    assign PCEn       = pc_write | (branch & Zero);
    assign state      = state_q;

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Control unit for the multicycle MIPS core that replaces the single-cycle decoder. It sequences one shared instruction/data memory, the register file, the ALU and PC update over several cycles per instruction through a Moore state machine. It also holds each memory access until the memory returns a ready handshake.

## Interface
- No parameters; opcode, funct, ALUControl and state encodings come from `mips_ctrl_pkg`.
- `clk  in  1`  rising-edge clock
- `reset_n  in  1`  asynchronous active-low reset
- `Op  in  6`  Instr[31:26] from the instruction register
- `Funct  in  6`  Instr[5:0] from the instruction register
- `Zero  in  1`  ALU zero flag
- `mem_ready  in  1`  memory completes the current access this cycle
- `mem_req  out  1`  memory access requested (FETCH, MEMRD, MEMWR)
- `IorD  out  1`  memory address select: 0 = PC, 1 = ALUOut
- `MemWrite  out  1`  write request, held high for the whole of MEMWR
- `IRWrite  out  1`  instruction register load enable
- `RegDst  out  1`  write register select: 0 = rt, 1 = rd
- `MemtoReg  out  1`  write-back select: 0 = ALUOut, 1 = Data
- `RegWrite  out  1`  register file write enable
- `ALUSrcA  out  1`  ALU A select: 0 = PC, 1 = A
- `ALUSrcB  out  2`  ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
- `ALUControl  out  3`  ALU operation
- `PCSrc  out  2`  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target
- `PCEn  out  1`  PC register enable
- `illegal_op  out  1`  one-cycle pulse in DECODE when Op is unsupported
- `state  out  4`  current state, for debug and the bench

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
- Transitions:
  - FETCH -> DECODE when mem_ready; otherwise stay in FETCH.
  - DECODE dispatches on Op:
    - lw/sw (100011/101011) -> MEMADR
    - R-type (000000) -> EXECUTE
    - beq (000100) -> BRANCH
    - addi (001000) -> ADDIEX
    - j (000010) -> JUMP
    - any other Op -> FETCH with illegal_op = 1
  - MEMADR -> MEMRD (lw) or MEMWR (sw).
  - MEMRD -> MEMWB when mem_ready; otherwise stay in MEMRD.
  - MEMWR -> FETCH when mem_ready; otherwise stay in MEMWR.
  - EXECUTE -> ALUWB; ADDIEX -> ADDIWB.
  - MEMWB, ALUWB, ADDIWB, BRANCH and JUMP -> FETCH.
- Moore outputs. Every signal not listed for a state is 0.
  - FETCH: mem_req=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=add, PCSrc=00. IRWrite=mem_ready, PCWrite=mem_ready, so PC+4 is applied exactly once.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=add (branch target precompute).
  - MEMADR and ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=add.
  - MEMRD: mem_req=1, IorD=1. MEMWR: mem_req=1, IorD=1, MemWrite=1.
  - MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. ALUWB: RegWrite=1, RegDst=1. ADDIWB: RegWrite=1, RegDst=0.
  - EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=funct.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=sub, PCSrc=01, Branch=1.
  - JUMP: PCSrc=10, PCWrite=1.
- PCEn = PCWrite | (Branch & Zero). This is combinational, so Zero is used in the same cycle.
- ALU decode:
  - ALUOp add -> 010; ALUOp sub -> 110.
  - ALUOp funct: add 100000 -> 010, sub 100010 -> 110, and 100100 -> 000, or 100101 -> 001, slt 101010 -> 111. Any other funct -> 010.

## Timing
- Reset (reset_n low, asynchronous): state = FETCH. mem_req, IRWrite, PCEn, RegWrite, MemWrite and illegal_op are forced to 0 while reset is held; all other outputs are also 0.
- First fetch request is in the first cycle after reset_n deasserts.
- Cycles per instruction at zero wait (mem_ready always 1): lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2. Each cycle mem_ready is low adds one cycle.
- Handshake: a request completes in the cycle mem_req=1 and mem_ready=1. mem_ready is ignored in all other states.
- Reset during MEMWR or MEMRD: MemWrite/mem_req drop immediately, and no register write or PC update occurs afterwards.

## Structure
- `mips_ctrl_pkg`: state_t enum (4-bit), opcode constants, funct constants, ALUControl constants and the aluop_t enum (add, sub, funct).
- Sub-module `mips_alu_decoder`: combinational, (ALUOp, Funct) -> ALUControl.
- The top module holds the state register, next-state logic, output decode and PCEn.

## Test plan
- Reset: hold reset_n=0 for 3 cycles with mem_ready=1 -> state=FETCH, every enable 0. Release -> IRWrite=1 and PCEn=1 in the next cycle.
- lw at zero wait: Op=100011 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB. RegWrite=1 and MemtoReg=1 only in cycle 5; IorD=1 in MEMRD.
- sw with 2 wait cycles: Op=101011, mem_ready low for 2 cycles in MEMWR -> MemWrite high for 3 consecutive cycles, then FETCH. RegWrite is never asserted.
- beq: Op=000100 with Zero=1 -> PCEn=1 and PCSrc=01 in BRANCH. With Zero=0 -> PCEn=0. Both cases return to FETCH.
- R-type slt and j: Funct=101010 -> ALUControl=111 in EXECUTE and RegDst=1 in ALUWB. Op=000010 -> PCSrc=10 and PCEn=1 in JUMP.
- Illegal Op=111111 -> illegal_op pulses for exactly 1 cycle in DECODE, then FETCH, with no writes. A reset asserted mid-MEMWR drops MemWrite in the same cycle.
